// File: rtl/asr_shift_scheduler_pkg.sv
// Shared constants and types for the two-requester arithmetic-right-shift scheduler.
package asr_sched_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SHW   = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_e;

    typedef logic id_t;

    // Result side-band carried alongside the shifted data.
    typedef struct packed {
        logic overflow;
        id_t  id;
    } rsp_tag_t;

endpackage

// File: rtl/asr_shift_scheduler_if.sv
// Request/response bus between the two requesters and the shift scheduler.
interface asr_shift_scheduler_if;
    import asr_sched_pkg::*;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_b1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_overflow;
    id_t              rsp_id;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_overflow, rsp_id
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_overflow, rsp_id
    );

endinterface

// File: rtl/asr_shift_scheduler_step.sv
// Bounded signed right shift: shifts by 0..STEP only, so it stays a small mux.
module asr_step
    import asr_sched_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [SHW-1:0]   s_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = a_i;
        for (int unsigned k = 1; k <= STEP; k++) begin
            if (s_i == SHW'(k)) begin
                y_o = WIDTH'($signed(a_i) >>> k);
            end
        end
    end

endmodule

// File: rtl/asr_shift_scheduler.sv
// Round-robin shared ASR datapath: accepts one op, shifts it STEP bits per cycle,
// then holds a tagged registered response until the consumer takes it.
module asr_shift_scheduler
    import asr_sched_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    asr_shift_scheduler_if.slave  bus,
    output logic                  busy
);

    localparam logic [WIDTH-1:0] MAX_AMT = WIDTH'(WIDTH - 1);
    localparam logic [SHW-1:0]   STEP_W  = SHW'(STEP);

    state_e           state_q, state_d;
    id_t              prio_q, prio_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   rem_q, rem_d;
    rsp_tag_t         tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    id_t              grant_c;
    logic             gnt_vld_c;
    logic [WIDTH-1:0] gnt_a_c;
    logic [WIDTH-1:0] gnt_b_c;
    logic [SHW-1:0]   step_amt_c;
    logic [WIDTH-1:0] step_y_c;

    // Arbiter: a lone requester always wins, a tie goes to the favoured one.
    always_comb begin
        gnt_vld_c = |bus.req_valid;
        grant_c   = 1'b0;
        case (bus.req_valid)
            2'b10:   grant_c = 1'b1;
            2'b11:   grant_c = prio_q;
            default: grant_c = 1'b0;
        endcase
        gnt_a_c = grant_c ? bus.req_a1 : bus.req_a0;
        gnt_b_c = grant_c ? bus.req_b1 : bus.req_b0;
    end

    assign bus.req_ready = (state_q == IDLE && gnt_vld_c) ? 2'(2'b01 << grant_c) : 2'b00;

    assign step_amt_c = (rem_q > STEP_W) ? STEP_W : rem_q;

    asr_step #(.STEP(STEP)) u_step (
        .a_i (data_q),
        .s_i (step_amt_c),
        .y_o (step_y_c)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        data_d  = data_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld_c) begin
                    data_d       = gnt_a_c;
                    rem_d        = (gnt_b_c > MAX_AMT) ? SHW'(WIDTH - 1) : SHW'(gnt_b_c);
                    tag_d.overflow = (gnt_b_c >= WIDTH'(WIDTH));
                    tag_d.id     = grant_c;
                    prio_d       = ~grant_c;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                data_d = step_y_c;
                rem_d  = rem_q - step_amt_c;
                if (rem_q == step_amt_c) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            data_q      <= '0;
            rem_q       <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            data_q      <= data_d;
            rem_q       <= rem_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_y        = data_q;
    assign bus.rsp_overflow = tag_q.overflow;
    assign bus.rsp_id       = tag_q.id;
    assign busy             = busy_q;

endmodule

// File: tb/tb_asr_shift_scheduler.sv
// Directed and randomized checks of asr_shift_scheduler against an arithmetic reference.
module tb_asr_shift_scheduler;
    import asr_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   errors = 0;
    int   checks = 0;
    logic tb_prio;

    asr_shift_scheduler_if bus ();

    asr_shift_scheduler #(.STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_y(input logic [15:0] a, input logic [15:0] b);
        return 16'($signed(a) >>> b);
    endfunction

    function automatic int ref_n(input logic [15:0] b);
        int e;
        e = (b > 16'd15) ? 15 : int'(b);
        return (e == 0) ? 1 : (e + 3) / 4;
    endfunction

    // Serve the currently presented request(s); entered and left at a falling edge.
    task automatic serve(input string tag, input int hold);
        logic [1:0]  v;
        logic        g;
        logic [15:0] a, b, y0;
        int          cyc;
        logic        ok;
        #1;
        v = bus.req_valid;
        g = (v == 2'b11) ? tb_prio : v[1];
        a = g ? bus.req_a1 : bus.req_a0;
        b = g ? bus.req_b1 : bus.req_b0;
        chk({tag, ":ready"}, 32'(bus.req_ready), 32'(g ? 2'b10 : 2'b01));
        @(posedge clk);
        tb_prio = ~g;
        cyc = 0;
        ok  = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.req_ready !== 2'b00) ok = 1'b0;
        end while (bus.rsp_valid !== 1'b1 && cyc < 50);
        chk({tag, ":latency"}, 32'(cyc), 32'(ref_n(b) + 1));
        chk({tag, ":y"}, 32'(bus.rsp_y), 32'(ref_y(a, b)));
        chk({tag, ":ovf"}, 32'(bus.rsp_overflow), 32'(b >= 16'd16));
        chk({tag, ":id"}, 32'(bus.rsp_id), 32'(g));
        y0 = bus.rsp_y;
        repeat (hold) begin
            @(negedge clk);
            if (bus.rsp_y !== y0 || bus.rsp_valid !== 1'b1 || bus.req_ready !== 2'b00 || busy !== 1'b1)
                ok = 1'b0;
        end
        chk({tag, ":held"}, 32'(ok), 32'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, ":idle"}, 32'({bus.rsp_valid, busy}), 32'd0);
    endtask

    task automatic op(input string tag, input logic id, input logic [15:0] a, input logic [15:0] b,
                      input int hold);
        if (id) begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_valid = 2'b10;
        end else begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_valid = 2'b01;
        end
        serve(tag, hold);
        bus.req_valid = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_a0 = '0; bus.req_a1 = '0;
        bus.req_b0 = '0; bus.req_b1 = '0;
        bus.rsp_ready = 1'b0;
        tb_prio = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset:outs", 32'({bus.rsp_valid, bus.rsp_y, bus.rsp_overflow, bus.rsp_id, busy}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op("basic0", 1'b0, 16'hC000, 16'd3, 0);
        op("basic1", 1'b0, 16'h8001, 16'd0, 0);

        for (int i = 0; i < 16; i++) op($sformatf("sweep%0d", i), 1'b1, 16'hC000, 16'(i), 0);

        op("ovf20", 1'b1, 16'h4000, 16'd20, 0);
        op("ovfmax", 1'b1, 16'h8000, 16'hFFFF, 0);

        // Both requesters held: grants must alternate.
        bus.req_a0 = 16'h8000; bus.req_b0 = 16'd1;
        bus.req_a1 = 16'h0100; bus.req_b1 = 16'd4;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) serve($sformatf("fair%0d", i), 0);

        // Stall the consumer with req1 still pending.
        serve("bp", 5);
        bus.req_valid = 2'b10;
        serve("bp_next", 0);
        bus.req_valid = 2'b00;

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(17));
            op($sformatf("rnd%0d", i), 1'($urandom_range(1)), ra, rb, int'($urandom_range(2)));
        end
        for (int i = 0; i < 10; i++) begin
            bus.req_a0 = 16'($urandom); bus.req_b0 = 16'($urandom_range(20));
            bus.req_a1 = 16'($urandom); bus.req_b1 = 16'($urandom_range(20));
            bus.req_valid = 2'b11;
            serve($sformatf("rndpair%0d", i), 0);
            bus.req_valid = 2'b00;
        end

        // Reset in the middle of a 3-cycle shift.
        bus.req_a0 = 16'h7FFF; bus.req_b0 = 16'd12; bus.req_valid = 2'b01;
        #1;
        chk("rst:ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("rst:busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst:outs", 32'({bus.rsp_valid, bus.rsp_y, bus.rsp_overflow, bus.rsp_id, busy}), 32'd0);
        tb_prio = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:no_rsp", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_a0 = 16'h1234; bus.req_b0 = 16'd5;
        bus.req_a1 = 16'hF000; bus.req_b1 = 16'd2;
        bus.req_valid = 2'b11;
        serve("post0", 0);
        serve("post1", 0);
        bus.req_valid = 2'b00;
        chk("post1:y_const", 32'(ref_y(16'hF000, 16'd2)), 32'h0000FC00);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
